plic_gateway: RTL and testbench

//   Per-source interrupt gateway that sequences raw peripheral interrupt lines into the PLIC core's request vector.

---
 rtl/plic_gateway.sv | 164 ++++++++++++++++
 tb/tb_plic_gateway.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_gateway.sv
// plic_gateway: per-source level/edge interrupt gateway feeding the PLIC core request vector.
// Define PLIC_GW_SYNC_EN to insert a two-flop synchronizer on every SrcIn bit (asynchronous pads).
//
// state      | meaning
// ST_IDLE    | nothing outstanding; trigger re-evaluated every cycle
// ST_PEND    | GwReq asserted, waiting for the claim of this ID
// ST_SERVICE | claimed by a hart, waiting for the complete of this ID
module plic_gateway #(
   parameter int NUM_SRC = 10,
   parameter int CNT_W   = 3
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   input  logic [NUM_SRC-1:0] SrcIn,
   input  logic [NUM_SRC-1:0] EdgeMode,
   input  logic               ClaimValid,
   input  logic [5:0]         ClaimID,
   input  logic               CompValid,
   input  logic [5:0]         CompID,
   input  logic               OvfClr,
   output logic [NUM_SRC-1:0] GwReq,
   output logic [NUM_SRC-1:0] Overflow
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PEND    = 2'd1,
      ST_SERVICE = 2'd2
   } gw_state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   gw_state_e          r_state     [NUM_SRC];
   gw_state_e          w_state_nxt [NUM_SRC];
   logic [CNT_W-1:0]   r_cnt       [NUM_SRC];
   logic [CNT_W-1:0]   w_cnt_nxt   [NUM_SRC];
   logic [NUM_SRC-1:0] r_src_q;
   logic [NUM_SRC-1:0] r_mode;
   logic [NUM_SRC-1:0] r_ovf;
   logic [NUM_SRC-1:0] w_s;
   logic [NUM_SRC-1:0] w_rise;
   logic [NUM_SRC-1:0] w_mode;
   logic [NUM_SRC-1:0] w_claim_hit;
   logic [NUM_SRC-1:0] w_comp_hit;
   logic [NUM_SRC-1:0] w_ovf_nxt;

`ifdef PLIC_GW_SYNC_EN
   logic [NUM_SRC-1:0] r_sync1;
   logic [NUM_SRC-1:0] r_sync2;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= SrcIn;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2;
`else
   assign w_s = SrcIn;
`endif

   assign w_rise = w_s & ~r_src_q;

   // IDs are 1-based; ID 0 and IDs above NUM_SRC never match any source.
   always_comb begin
      w_claim_hit = '0;
      w_comp_hit  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_claim_hit[i] = ClaimValid && (ClaimID == 6'(i + 1));
         w_comp_hit[i]  = CompValid  && (CompID  == 6'(i + 1));
      end
   end

   // Mode is followed live in IDLE and frozen for the rest of a request lifetime.
   always_comb begin
      w_mode = r_mode;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (r_state[i] == ST_IDLE) begin
            w_mode[i] = EdgeMode[i];
         end
      end
   end

   always_comb begin
      w_ovf_nxt = r_ovf & ~{NUM_SRC{OvfClr}};
      for (int i = 0; i < NUM_SRC; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
         case (r_state[i])
            ST_IDLE: begin
               if (w_mode[i]) begin
                  // A fresh rise is consumed directly; otherwise replay one stored edge.
                  if (w_rise[i]) begin
                     w_state_nxt[i] = ST_PEND;
                  end else if (r_cnt[i] != '0) begin
                     w_state_nxt[i] = ST_PEND;
                     w_cnt_nxt[i]   = r_cnt[i] - CNT_ONE;
                  end
               end else if (w_s[i]) begin
                  w_state_nxt[i] = ST_PEND;
               end
            end
            ST_PEND: begin
               if (w_claim_hit[i]) begin
                  w_state_nxt[i] = ST_SERVICE;
               end
            end
            ST_SERVICE: begin
               if (w_comp_hit[i]) begin
                  w_state_nxt[i] = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt[i] = ST_IDLE;
            end
         endcase
         if (w_mode[i] && w_rise[i] && (r_state[i] != ST_IDLE)) begin
            if (r_cnt[i] == CNT_MAX) begin
               w_ovf_nxt[i] = 1'b1;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
            end
         end
         if (!w_mode[i]) begin
            w_cnt_nxt[i] = '0;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_src_q <= '0;
         r_mode  <= '0;
         r_ovf   <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
         end
      end else begin
         r_src_q <= w_s;
         r_mode  <= w_mode;
         r_ovf   <= w_ovf_nxt;
         for (int i = 0; i < NUM_SRC; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
         end
      end
   end

   always_comb begin
      GwReq = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         GwReq[i] = (r_state[i] == ST_PEND);
      end
   end

   assign Overflow = r_ovf;

endmodule

// File: tb/tb_plic_gateway.sv
// tb_plic_gateway: directed and random stimulus for plic_gateway, checked every cycle against a
// per-source request/edge-count reference model.
module tb_plic_gateway;

   localparam int N    = 10;
   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;
   localparam int IDLE = 0;
   localparam int PEND = 1;
   localparam int SERV = 2;

   logic         PCLK = 1'b0;
   logic         PRESETn;
   logic [N-1:0] SrcIn;
   logic [N-1:0] EdgeMode;
   logic         ClaimValid;
   logic [5:0]   ClaimID;
   logic         CompValid;
   logic [5:0]   CompID;
   logic         OvfClr;
   logic [N-1:0] GwReq;
   logic [N-1:0] Overflow;

   int n_assert = 0;
   int n_fail   = 0;

   int           m_st  [N];
   int           m_cnt [N];
   logic [N-1:0] m_ovf;
   logic [N-1:0] m_mode;
   logic [N-1:0] m_prev;
   logic [N-1:0] m_sync1;
   logic [N-1:0] m_sync2;

   plic_gateway #(.NUM_SRC(N), .CNT_W(CW)) dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .SrcIn      (SrcIn),
      .EdgeMode   (EdgeMode),
      .ClaimValid (ClaimValid),
      .ClaimID    (ClaimID),
      .CompValid  (CompValid),
      .CompID     (CompID),
      .OvfClr     (OvfClr),
      .GwReq      (GwReq),
      .Overflow   (Overflow)
   );

   always #5 PCLK = ~PCLK;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i]  = IDLE;
         m_cnt[i] = 0;
      end
      m_ovf   = '0;
      m_mode  = '0;
      m_prev  = '0;
      m_sync1 = '0;
      m_sync2 = '0;
   endfunction

   // One clock edge of the gateway rules, using the inputs held across that edge.
   function automatic void model_step();
      logic [N-1:0] s;
`ifdef PLIC_GW_SYNC_EN
      s       = m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = SrcIn;
`else
      s = SrcIn;
`endif
      for (int i = 0; i < N; i++) begin
         int id;
         int old;
         bit rise;
         bit is_edge;
         bit set_ovf;
         id      = i + 1;
         old     = m_st[i];
         rise    = s[i] && !m_prev[i];
         is_edge = (old == IDLE) ? EdgeMode[i] : m_mode[i];
         set_ovf = 0;
         if (old == IDLE) begin
            if (is_edge) begin
               if (rise) m_st[i] = PEND;
               else if (m_cnt[i] > 0) begin
                  m_cnt[i] = m_cnt[i] - 1;
                  m_st[i]  = PEND;
               end
            end else if (s[i]) begin
               m_st[i] = PEND;
            end
         end else begin
            if (old == PEND && ClaimValid && ClaimID == id) m_st[i] = SERV;
            if (old == SERV && CompValid && CompID == id) m_st[i] = IDLE;
            if (is_edge && rise) begin
               if (m_cnt[i] == CMAX) set_ovf = 1;
               else m_cnt[i] = m_cnt[i] + 1;
            end
         end
         if (!is_edge) m_cnt[i] = 0;
         if (set_ovf) m_ovf[i] = 1'b1;
         else if (OvfClr) m_ovf[i] = 1'b0;
         m_mode[i] = is_edge;
         m_prev[i] = s[i];
      end
   endfunction

   task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] exp_req;
      for (int i = 0; i < N; i++) exp_req[i] = (m_st[i] == PEND);
      check_vec("gwreq", GwReq, exp_req);
      check_vec("overflow", Overflow, m_ovf);
   endtask

   task automatic tick();
      @(posedge PCLK);
      if (PRESETn) model_step();
      else model_reset();
      #1;
      check_outputs();
   endtask

   task automatic claim(input int id);
      ClaimValid = 1'b1;
      ClaimID    = 6'(id);
      tick();
      ClaimValid = 1'b0;
      ClaimID    = '0;
   endtask

   task automatic complete(input int id);
      CompValid = 1'b1;
      CompID    = 6'(id);
      tick();
      CompValid = 1'b0;
      CompID    = '0;
   endtask

   task automatic pulse(input int b);
      SrcIn[b] = 1'b1;
      tick();
      SrcIn[b] = 1'b0;
      tick();
   endtask

   task automatic wait_req(input int b, input int budget);
      int k;
      k = 0;
      while (GwReq[b] !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      check_int($sformatf("wait_req_%0d", b), int'(GwReq[b]), 1);
   endtask

   initial begin
      int n_fwd;
      int k;
      PRESETn    = 1'b0;
      SrcIn      = '0;
      EdgeMode   = '0;
      ClaimValid = 1'b0;
      ClaimID    = '0;
      CompValid  = 1'b0;
      CompID     = '0;
      OvfClr     = 1'b0;
      model_reset();
      #1;
      check_vec("reset_gwreq", GwReq, '0);
      check_vec("reset_ovf", Overflow, '0);
      tick();
      tick();
      PRESETn = 1'b1;
      tick();

      // Level source ID 3: forward, claim, complete, re-forward while still high.
      SrcIn[2] = 1'b1;
      wait_req(2, 5);
      claim(3);
      check_int("lvl_claimed", int'(GwReq[2]), 0);
      complete(3);
      check_int("lvl_comp_idle", int'(GwReq[2]), 0);
      tick();
      check_int("lvl_reforward", int'(GwReq[2]), 1);
      SrcIn[2] = 1'b0;
      repeat (3) tick();
      claim(3);
      complete(3);
      repeat (4) tick();
      check_int("lvl_quiet", int'(GwReq[2]), 0);

      // Edge source ID 1: three edges during SERVICE give exactly three more requests.
      EdgeMode[0] = 1'b1;
      pulse(0);
      wait_req(0, 4);
      claim(1);
      repeat (3) pulse(0);
      repeat (3) tick();
      complete(1);
      n_fwd = 0;
      for (int r = 0; r < 5; r++) begin
         k = 0;
         while (GwReq[0] !== 1'b1 && k < 6) begin
            tick();
            k++;
         end
         if (GwReq[0] === 1'b1) begin
            n_fwd++;
            claim(1);
            complete(1);
         end
      end
      check_int("edge_reforward_count", n_fwd, 3);

      // Edge source ID 2: saturate the counter while PEND, then overflow handling.
      EdgeMode[1] = 1'b1;
      pulse(1);
      wait_req(1, 4);
      repeat (9) pulse(1);
      repeat (3) tick();
      check_int("ovf_set", int'(Overflow[1]), 1);
      SrcIn[1] = 1'b1;
      OvfClr   = 1'b1;
      tick();
      OvfClr   = 1'b0;
      SrcIn[1] = 1'b0;
      repeat (3) tick();
      OvfClr = 1'b1;
      tick();
      OvfClr = 1'b0;
      check_int("ovf_clear", int'(Overflow[1]), 0);
      claim(2);
      EdgeMode[1] = 1'b0;
      complete(2);
      repeat (3) tick();
      check_int("mode_change_drops_count", int'(GwReq[1]), 0);

      // Bad IDs and out-of-state strobes are ignored.
      pulse(0);
      wait_req(0, 4);
      claim(0);
      claim(63);
      complete(5);
      complete(1);
      check_vec("bad_ids", GwReq, N'(1));
      claim(1);
      complete(1);

      // Simultaneous claim and complete on different sources.
      pulse(0);
      wait_req(0, 4);
      SrcIn[1] = 1'b1;
      wait_req(1, 5);
      claim(2);
      SrcIn[1]   = 1'b0;
      ClaimValid = 1'b1;
      ClaimID    = 6'd1;
      CompValid  = 1'b1;
      CompID     = 6'd2;
      tick();
      ClaimValid = 1'b0;
      CompValid  = 1'b0;
      check_int("simul_src1_claimed", int'(GwReq[0]), 0);
      check_int("simul_src2_idle", int'(GwReq[1]), 0);
      repeat (3) tick();
      SrcIn[1] = 1'b1;
      wait_req(1, 5);
      complete(1);
      pulse(0);
      wait_req(0, 4);
      ClaimValid = 1'b1;
      ClaimID    = 6'd1;
      CompValid  = 1'b1;
      CompID     = 6'd2;
      tick();
      ClaimValid = 1'b0;
      CompValid  = 1'b0;
      check_int("pend_ignores_comp", int'(GwReq[1]), 1);
      check_int("simul_claim_only", int'(GwReq[0]), 0);
      SrcIn[1] = 1'b0;
      repeat (3) tick();
      claim(2);
      complete(2);
      complete(1);
      repeat (3) tick();

      // Source 4 in SERVICE with two stored edges, then asynchronous reset.
      EdgeMode[3] = 1'b1;
      pulse(3);
      wait_req(3, 4);
      claim(4);
      pulse(3);
      pulse(3);
      repeat (3) tick();
      #2;
      PRESETn = 1'b0;
      #1;
      check_vec("rst_async_gwreq", GwReq, '0);
      check_vec("rst_async_ovf", Overflow, '0);
      model_reset();
      tick();
      PRESETn = 1'b1;
      repeat (6) tick();
      check_vec("rst_no_reforward", GwReq, '0);

      // Random traffic against the model.
      EdgeMode = N'($urandom);
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 3) == 0) SrcIn[b] = ~SrcIn[b];
         end
         if ($urandom_range(0, 31) == 0) EdgeMode = N'($urandom);
         ClaimValid = ($urandom_range(0, 2) == 0);
         ClaimID    = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(1, N)) : 6'($urandom_range(0, 63));
         CompValid  = ($urandom_range(0, 2) == 0);
         CompID     = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(1, N)) : 6'($urandom_range(0, 63));
         OvfClr     = ($urandom_range(0, 15) == 0);
         tick();
      end
      SrcIn      = '0;
      ClaimValid = 1'b0;
      CompValid  = 1'b0;
      OvfClr     = 1'b0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
